sdram_read_arbiter: RTL and testbench
=====================================

// Module: sdram_read_arbiter
// PURPOSE
// - Shares the single f2h_sdram Avalon-MM burst-read port between two read masters.
//   m0 = frame reader (video, high priority); m1 = secondary reader (DMA/diagnostics).
// - Sits between the readers and soc_system f2h_sdram; one clock domain (sdram_clk).
// - Tracks outstanding bursts so returning beats are routed to the issuing master.
// PARAMETERS
// - ADDR_W    29  Avalon word address width (all address ports).
// - BURST_W   8   burstcount width (all burstcount ports).
// - DATA_W    64  readdata width (all readdata ports).
// - MAX_OUTST 4   max accepted-but-incomplete bursts; tracking FIFO depth (power of 2).
// PORTS
// - clk                 in   1        sdram-side clock
// - rst                 in   1        synchronous reset, active-high
// - mN_address          in   ADDR_W   master N address, N=0,1
// - mN_burstcount       in   BURST_W  master N burst length in beats
// - mN_read             in   1        master N read request; held until accepted
// - mN_waitrequest      out  1        master N stall
// - mN_readdata         out  DATA_W   return data (same bus to both masters)
// - mN_readdatavalid    out  1        beat valid for master N
// - s_address           out  ADDR_W   to f2h_sdram address
// - s_burstcount        out  BURST_W  to f2h_sdram burstcount
// - s_read              out  1        to f2h_sdram read
// - s_waitrequest       in   1        from f2h_sdram waitrequest
// - s_readdata          in   DATA_W   from f2h_sdram readdata
// - s_readdatavalid     in   1        from f2h_sdram readdatavalid
// - outstanding_o       out  $clog2(MAX_OUTST)+1  tracked bursts in FIFO
// - stray_rdv_o         out  1        1-cycle pulse: beat arrived with tracking FIFO empty
// BEHAVIOUR
// - Reset: s_read=0, s_address/s_burstcount=0, mN_waitrequest=1, mN_readdatavalid=0,
//   mN_readdata=0, outstanding_o=0, stray_rdv_o=0, FSM=IDLE, FIFO empty, beat count=0.
// - FSM IDLE: if FIFO not full and any mN_read=1, register grant and go GRANT next cycle.
//   FIFO full: stay IDLE, no grant; all mN_waitrequest=1.
// - FSM GRANT: s_address/s_burstcount/s_read driven combinationally from granted master;
//   granted mN_waitrequest = s_waitrequest; ungranted master waitrequest=1.
//   Accept = s_read & ~s_waitrequest: push {id,burstcount} to FIFO, return to IDLE.
//   Grant held while s_waitrequest=1; no preemption of a granted request.
// - Command latency: mN_read rising in IDLE -> s_read asserted 1 cycle later (min).
// - Back-to-back: one command per 2 cycles max (IDLE/GRANT alternation).
// - Burstcount 0: treated as 1 beat for tracking (illegal Avalon; sim assertion fires).
// - Return path: s_readdata/s_readdatavalid registered, 1-cycle latency; readdatavalid
//   routed to FIFO head id; beat counter increments per beat; on beat==burstcount, pop
//   head and clear counter in the same cycle.
// - Push and pop in same cycle: both take effect; outstanding_o unchanged.
// - s_readdatavalid with FIFO empty: beat dropped (no mN_readdatavalid), stray_rdv_o=1.
// - Reset mid-burst: FIFO and counter cleared; later returning beats count as stray.
// - Arbitration (default, fixed priority): m0 wins when both request in IDLE.
// CONFIGURATION
// - SDRAM_ARB_ROUND_ROBIN_EN defined: round-robin; master granted last gets lower
//   priority on next simultaneous request (last-grant reset value = m1, so m0 first).
// - Undefined: fixed priority m0 > m1; m1 may starve while m0 requests continuously.
// TESTING
// - m0 only, addr 0x100, bc 8, s_waitrequest=0 -> s_read 1 cycle after request; 8 beats
//   on m0_readdatavalid, each 1 cycle after s_readdatavalid; outstanding_o 1->0.
// - m0,m1 request same cycle (fixed prio) -> m0 issued first, m1 issued 2 cycles later;
//   with ROUND_ROBIN_EN and m0 served last -> m1 issued first.
// - 4 bursts accepted (bc 2) with data withheld -> outstanding_o=4, 5th request held
//   (waitrequest=1) until first burst's 2nd beat pops FIFO.
// - s_waitrequest=1 for 5 cycles during grant -> s_address/s_burstcount stable, other
//   master not granted; accept on cycle 6.
// - Interleaved m0 bc 3 then m1 bc 2 -> beats 1-3 to m0 only, beats 4-5 to m1 only.
// - rst asserted mid-burst, then 2 beats arrive -> no mN_readdatavalid, stray_rdv_o 2 pulses.

Source files
------------

// File: rtl/sdram_read_arbiter.sv
// Two-master burst-read arbiter onto one f2h_sdram port; define SDRAM_ARB_ROUND_ROBIN_EN for round-robin, else fixed m0 > m1.
// Latency: request -> s_read 1 cycle; s_readdatavalid -> mN_readdatavalid 1 cycle. Backpressure: mN_waitrequest
// stays high until the granted master sees s_waitrequest low; no grants while MAX_OUTST bursts are outstanding.
module sdram_read_arbiter #(
    parameter int ADDR_W    = 29,
    parameter int BURST_W   = 8,
    parameter int DATA_W    = 64,
    parameter int MAX_OUTST = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_W-1:0]         m0_address,
    input  logic [BURST_W-1:0]        m0_burstcount,
    input  logic                      m0_read,
    output logic                      m0_waitrequest,
    output logic [DATA_W-1:0]         m0_readdata,
    output logic                      m0_readdatavalid,
    input  logic [ADDR_W-1:0]         m1_address,
    input  logic [BURST_W-1:0]        m1_burstcount,
    input  logic                      m1_read,
    output logic                      m1_waitrequest,
    output logic [DATA_W-1:0]         m1_readdata,
    output logic                      m1_readdatavalid,
    output logic [ADDR_W-1:0]         s_address,
    output logic [BURST_W-1:0]        s_burstcount,
    output logic                      s_read,
    input  logic                      s_waitrequest,
    input  logic [DATA_W-1:0]         s_readdata,
    input  logic                      s_readdatavalid,
    output logic [$clog2(MAX_OUTST):0] outstanding_o,
    output logic                      stray_rdv_o
);
    localparam int PTR_W = $clog2(MAX_OUTST);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state, state_nxt;
    logic               grant_id, grant_id_nxt, pick_id;
    logic               push, pop, fifo_full, fifo_empty;
    logic [CNT_W-1:0]   count;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic               fifo_id  [MAX_OUTST];
    logic [BURST_W-1:0] fifo_len [MAX_OUTST];
    logic [BURST_W-1:0] push_len, head_len, beat_cnt;
    logic               head_id, rdv_hit, last_beat;
    logic [DATA_W-1:0]  readdata_q;
    logic               rdv0_q, rdv1_q, stray_q;

    assign fifo_full     = (count == CNT_W'(MAX_OUTST));
    assign fifo_empty    = (count == '0);
    assign outstanding_o = count;

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    logic last_grant;

    // Whoever won the previous grant yields on a tie; reset value favours m0 first.
    always_comb begin
        pick_id = m1_read & ~m0_read;
        if (m0_read && m1_read) pick_id = ~last_grant;
    end

    always_ff @(posedge clk) begin
        if (rst) last_grant <= 1'b1;
        else if (state == IDLE && state_nxt == GRANT) last_grant <= pick_id;
    end
`else
    assign pick_id = ~m0_read;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            grant_id <= 1'b0;
        end else begin
            state    <= state_nxt;
            grant_id <= grant_id_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        grant_id_nxt   = grant_id;
        s_read         = 1'b0;
        s_address      = '0;
        s_burstcount   = '0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        push           = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_full && (m0_read || m1_read)) begin
                    state_nxt    = GRANT;
                    grant_id_nxt = pick_id;
                end
            end
            GRANT: begin
                s_read       = 1'b1;
                s_address    = grant_id ? m1_address : m0_address;
                s_burstcount = grant_id ? m1_burstcount : m0_burstcount;
                if (grant_id) m1_waitrequest = s_waitrequest;
                else          m0_waitrequest = s_waitrequest;
                if (!s_waitrequest) begin
                    push      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A zero burstcount is tracked as a single beat so the return path cannot stall.
    assign push_len  = (s_burstcount == '0) ? BURST_W'(1) : s_burstcount;
    assign head_id   = fifo_id[rd_ptr];
    assign head_len  = fifo_len[rd_ptr];
    assign rdv_hit   = s_readdatavalid && !fifo_empty;
    assign last_beat = (beat_cnt == head_len - BURST_W'(1));
    assign pop       = rdv_hit && last_beat;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_id[wr_ptr]  <= grant_id;
            fifo_len[wr_ptr] <= push_len;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            beat_cnt   <= '0;
            readdata_q <= '0;
            rdv0_q     <= 1'b0;
            rdv1_q     <= 1'b0;
            stray_q    <= 1'b0;
        end else begin
            readdata_q <= s_readdata;
            rdv0_q     <= rdv_hit && !head_id;
            rdv1_q     <= rdv_hit && head_id;
            stray_q    <= s_readdatavalid && fifo_empty;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (rdv_hit) beat_cnt <= last_beat ? '0 : beat_cnt + BURST_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) assert (s_burstcount != '0);
    end

    assign m0_readdata      = readdata_q;
    assign m1_readdata      = readdata_q;
    assign m0_readdatavalid = rdv0_q;
    assign m1_readdatavalid = rdv1_q;
    assign stray_rdv_o      = stray_q;
endmodule

// File: tb/tb_sdram_read_arbiter.sv
// Directed bench for sdram_read_arbiter: command and beat scoreboards checked by a negedge monitor.
module tb_sdram_read_arbiter;
    localparam int ADDR_W = 29, BURST_W = 8, DATA_W = 64, MAX_OUTST = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic [ADDR_W-1:0]  m0_address, m1_address, s_address;
    logic [BURST_W-1:0] m0_burstcount, m1_burstcount, s_burstcount;
    logic               m0_read, m1_read, m0_waitrequest, m1_waitrequest;
    logic [DATA_W-1:0]  m0_readdata, m1_readdata, s_readdata;
    logic               m0_readdatavalid, m1_readdatavalid;
    logic               s_read, s_waitrequest, s_readdatavalid;
    logic [2:0]         outstanding_o;
    logic               stray_rdv_o;

    int tests = 0, fails = 0, cyc = 0, stray_cnt = 0, prev_acc = 0, last_acc = 0;
    int mon_id;
    bit                 exp_cmd_id[$];
    logic [ADDR_W-1:0]  exp_cmd_addr[$];
    logic [BURST_W-1:0] exp_cmd_bc[$];
    bit                 exp_id[$];
    logic [DATA_W-1:0]  exp_dat[$];

    sdram_read_arbiter #(.ADDR_W(ADDR_W), .BURST_W(BURST_W), .DATA_W(DATA_W), .MAX_OUTST(MAX_OUTST)) dut (
        .clk(clk), .rst(rst),
        .m0_address(m0_address), .m0_burstcount(m0_burstcount), .m0_read(m0_read),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_burstcount(m1_burstcount), .m1_read(m1_read),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .s_address(s_address), .s_burstcount(s_burstcount), .s_read(s_read),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
        .outstanding_o(outstanding_o), .stray_rdv_o(stray_rdv_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_cmd(input bit id, input logic [ADDR_W-1:0] a, input logic [BURST_W-1:0] bc);
        exp_cmd_id.push_back(id);
        exp_cmd_addr.push_back(a);
        exp_cmd_bc.push_back(bc);
    endtask

    task automatic check_beat(input bit id, input logic [DATA_W-1:0] d);
        chk("beat_pending", 64'(exp_id.size() > 0), 1);
        if (exp_id.size() > 0) begin
            chk("beat_master", 64'(id), 64'(exp_id.pop_front()));
            chk("beat_data", d, exp_dat.pop_front());
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst) begin
            if (s_read && !s_waitrequest) begin
                prev_acc = last_acc;
                last_acc = cyc;
                chk("cmd_pending", 64'(exp_cmd_id.size() > 0), 1);
                if (exp_cmd_id.size() > 0) begin
                    mon_id = !m0_waitrequest ? 0 : (!m1_waitrequest ? 1 : 2);
                    chk("cmd_master", 64'(mon_id), 64'(exp_cmd_id.pop_front()));
                    chk("cmd_addr", 64'(s_address), 64'(exp_cmd_addr.pop_front()));
                    chk("cmd_bc", 64'(s_burstcount), 64'(exp_cmd_bc.pop_front()));
                end
            end
            if (m0_readdatavalid) check_beat(1'b0, m0_readdata);
            if (m1_readdatavalid) check_beat(1'b1, m1_readdata);
            if (stray_rdv_o) stray_cnt++;
        end
    end

    task automatic drop_read(input bit id);
        if (id) m1_read = 1'b0; else m0_read = 1'b0;
    endtask

    task automatic wait_accept(input bit id);
        int n;
        n = 0;
        while (n < 50) begin
            @(negedge clk);
            if ((id ? m1_waitrequest : m0_waitrequest) == 1'b0) break;
            n++;
        end
        chk("accept_in_time", 64'(n < 50), 1);
        @(posedge clk); #1;
        drop_read(id);
    endtask

    task automatic issue(input bit id, input logic [ADDR_W-1:0] a, input logic [BURST_W-1:0] bc);
        @(posedge clk); #1;
        if (id) begin m1_address = a; m1_burstcount = bc; m1_read = 1'b1; end
        else    begin m0_address = a; m0_burstcount = bc; m0_read = 1'b1; end
        wait_accept(id);
    endtask

    task automatic beats(input int n, input bit id, input logic [DATA_W-1:0] base, input bit tail);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            s_readdatavalid = 1'b1;
            s_readdata      = base + DATA_W'(i);
            exp_id.push_back(id);
            exp_dat.push_back(base + DATA_W'(i));
        end
        if (tail) begin
            @(posedge clk); #1;
            s_readdatavalid = 1'b0;
            s_readdata      = '0;
        end
    endtask

    task automatic drained(input string tag);
        @(posedge clk); #1;
        chk({tag, "_beats_left"}, 64'(exp_id.size()), 0);
        chk({tag, "_outstanding"}, 64'(outstanding_o), 0);
    endtask

    initial begin
        bit first;
        int stray_before;
        rst = 1'b1;
        m0_address = '0; m0_burstcount = '0; m0_read = 1'b0;
        m1_address = '0; m1_burstcount = '0; m1_read = 1'b0;
        s_waitrequest = 1'b0; s_readdatavalid = 1'b0; s_readdata = 64'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_read", 64'(s_read), 0);
        chk("rst_s_address", 64'(s_address), 0);
        chk("rst_s_burstcount", 64'(s_burstcount), 0);
        chk("rst_m0_wait", 64'(m0_waitrequest), 1);
        chk("rst_m1_wait", 64'(m1_waitrequest), 1);
        chk("rst_rdv", 64'({m0_readdatavalid, m1_readdatavalid}), 0);
        chk("rst_readdata", m0_readdata, 0);
        chk("rst_outstanding", 64'(outstanding_o), 0);
        chk("rst_stray", 64'(stray_rdv_o), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single m0 burst of 8: command latency, return routing, occupancy.
        push_cmd(1'b0, 29'h100, 8'd8);
        @(posedge clk); #1;
        m0_address = 29'h100; m0_burstcount = 8'd8; m0_read = 1'b1;
        @(negedge clk);
        chk("s1_idle_sread", 64'(s_read), 0);
        chk("s1_idle_wait", 64'(m0_waitrequest), 1);
        @(negedge clk);
        chk("s1_sread_latency", 64'(s_read), 1);
        chk("s1_m1_not_granted", 64'(m1_waitrequest), 1);
        @(posedge clk); #1;
        m0_read = 1'b0;
        @(negedge clk);
        chk("s1_outstanding", 64'(outstanding_o), 1);
        beats(8, 1'b0, 64'h1000, 1'b1);
        drained("s1");

        // Simultaneous requests.
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
        first = 1'b1;
`else
        first = 1'b0;
`endif
        push_cmd(first, first ? 29'h300 : 29'h200, 8'd1);
        push_cmd(~first, first ? 29'h200 : 29'h300, 8'd1);
        fork
            issue(1'b0, 29'h200, 8'd1);
            issue(1'b1, 29'h300, 8'd1);
        join
        chk("s2_issue_gap", 64'(last_acc - prev_acc), 2);
        chk("s2_outstanding", 64'(outstanding_o), 2);
        beats(1, first, 64'h2000, 1'b0);
        beats(1, ~first, 64'h2100, 1'b1);
        drained("s2");

        // Slave stalls the granted m1 for 5 cycles while m0 waits.
        push_cmd(1'b1, 29'h400, 8'd5);
        push_cmd(1'b0, 29'h500, 8'd3);
        @(posedge clk); #1;
        s_waitrequest = 1'b1;
        m1_address = 29'h400; m1_burstcount = 8'd5; m1_read = 1'b1;
        @(posedge clk); #1;
        m0_address = 29'h500; m0_burstcount = 8'd3; m0_read = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("s3_stall_addr", 64'(s_address), 64'h400);
            chk("s3_stall_bc", 64'(s_burstcount), 5);
            chk("s3_stall_waits", 64'({m0_waitrequest, m1_waitrequest}), 64'b11);
        end
        @(posedge clk); #1;
        s_waitrequest = 1'b0;
        wait_accept(1'b1);
        wait_accept(1'b0);
        beats(5, 1'b1, 64'h3000, 1'b0);
        beats(3, 1'b0, 64'h3100, 1'b1);
        drained("s3");

        // Interleaved m0 bc3 then m1 bc2 on one contiguous beat stream.
        push_cmd(1'b0, 29'h700, 8'd3);
        push_cmd(1'b1, 29'h800, 8'd2);
        issue(1'b0, 29'h700, 8'd3);
        issue(1'b1, 29'h800, 8'd2);
        beats(3, 1'b0, 64'h4000, 1'b0);
        beats(2, 1'b1, 64'h4100, 1'b1);
        drained("s4");

        // Fill the tracking FIFO; a fifth request waits for the first pop.
        for (int i = 0; i < 4; i++) begin
            push_cmd(1'b0, 29'h1000 + 29'(i), 8'd2);
            issue(1'b0, 29'h1000 + 29'(i), 8'd2);
        end
        @(negedge clk);
        chk("s5_full", 64'(outstanding_o), 4);
        push_cmd(1'b1, 29'h600, 8'd1);
        @(posedge clk); #1;
        m1_address = 29'h600; m1_burstcount = 8'd1; m1_read = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("s5_held_wait", 64'(m1_waitrequest), 1);
            chk("s5_held_sread", 64'(s_read), 0);
        end
        beats(1, 1'b0, 64'h5000, 1'b1);
        @(negedge clk);
        chk("s5_held_after_beat1", 64'(m1_waitrequest), 1);
        chk("s5_still_full", 64'(outstanding_o), 4);
        beats(1, 1'b0, 64'h5001, 1'b1);
        wait_accept(1'b1);
        beats(6, 1'b0, 64'h5100, 1'b0);
        beats(1, 1'b1, 64'h5200, 1'b1);
        drained("s5");
        chk("no_stray_so_far", 64'(stray_cnt), 0);

        // Reset mid-burst; remaining beats become strays.
        push_cmd(1'b0, 29'h900, 8'd4);
        issue(1'b0, 29'h900, 8'd4);
        beats(1, 1'b0, 64'h6000, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("s6_outstanding_cleared", 64'(outstanding_o), 0);
        stray_before = stray_cnt;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            s_readdatavalid = 1'b1;
            s_readdata      = 64'h6100 + 64'(i);
        end
        @(posedge clk); #1;
        s_readdatavalid = 1'b0;
        @(posedge clk); #1;
        chk("s6_stray_pulses", 64'(stray_cnt - stray_before), 2);
        chk("final_cmds_left", 64'(exp_cmd_id.size()), 0);
        chk("final_beats_left", 64'(exp_id.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
